// File: rtl/read_buffer_ctrl.sv
// Line read controller for a pixel line striped over three single-port banks.
// Streams pixels in order and builds a 3-tap horizontal window with border replication.
module read_buffer_ctrl #(
  parameter int DATA_WD  = 8,
  parameter int RAM_WD   = 8,
  parameter int LINE_LEN = 640
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [DATA_WD-1:0] ram0_rdata_i,
  input  logic [DATA_WD-1:0] ram1_rdata_i,
  input  logic [DATA_WD-1:0] ram2_rdata_i,
  output logic [RAM_WD-1:0]  ram0_addr_o,
  output logic [RAM_WD-1:0]  ram1_addr_o,
  output logic [RAM_WD-1:0]  ram2_addr_o,
  output logic               ram0_en_o,
  output logic               ram1_en_o,
  output logic               ram2_en_o,
  output logic [DATA_WD-1:0] pix_o,
  output logic               pix_valid_o,
  output logic [DATA_WD-1:0] win_l_o,
  output logic [DATA_WD-1:0] win_c_o,
  output logic [DATA_WD-1:0] win_r_o,
  output logic               win_valid_o,
  output logic [9:0]         win_x_o,
  output logic               sol_o,
  output logic               eol_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int CW = $clog2(LINE_LEN + 1);
  localparam logic [CW-1:0] RD_END = CW'(LINE_LEN);
  localparam logic [9:0]    LAST_X = 10'(LINE_LEN - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e              state_q;
  logic [CW-1:0]       rdCnt_q;
  logic [1:0]          bankCnt_q;
  logic [RAM_WD-1:0]   addrCnt_q;

  logic                rdValid_q;
  logic [1:0]          rdBank_q;
  logic [DATA_WD-1:0]  rdData;
  logic [DATA_WD-1:0]  tapA_q;
  logic [DATA_WD-1:0]  tapB_q;
  logic                aValid_q;
  logic [9:0]          winCnt_q;
  logic                abortHit;
  logic                emit;

  assign abortHit = abort_i && ((state_q == READ) || (state_q == DRAIN));

  // Read sequencer: rdCnt/bankCnt/addrCnt always describe the next read to issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rdCnt_q     <= '0;
      bankCnt_q   <= '0;
      addrCnt_q   <= '0;
      ram0_addr_o <= '0;
      ram1_addr_o <= '0;
      ram2_addr_o <= '0;
      ram0_en_o   <= 1'b0;
      ram1_en_o   <= 1'b0;
      ram2_en_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abortHit) begin
        state_q     <= IDLE;
        rdCnt_q     <= '0;
        bankCnt_q   <= '0;
        addrCnt_q   <= '0;
        ram0_addr_o <= '0;
        ram1_addr_o <= '0;
        ram2_addr_o <= '0;
        ram0_en_o   <= 1'b0;
        ram1_en_o   <= 1'b0;
        ram2_en_o   <= 1'b0;
        busy_o      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q     <= READ;
              busy_o      <= 1'b1;
              ram0_en_o   <= 1'b1;
              ram1_en_o   <= 1'b0;
              ram2_en_o   <= 1'b0;
              ram0_addr_o <= '0;
              ram1_addr_o <= '0;
              ram2_addr_o <= '0;
              bankCnt_q   <= 2'd1;
              addrCnt_q   <= '0;
              rdCnt_q     <= CW'(1);
            end
          end
          READ: begin
            if (rdCnt_q == RD_END) begin
              ram0_en_o <= 1'b0;
              ram1_en_o <= 1'b0;
              ram2_en_o <= 1'b0;
              state_q   <= DRAIN;
            end else begin
              ram0_en_o   <= (bankCnt_q == 2'd0);
              ram1_en_o   <= (bankCnt_q == 2'd1);
              ram2_en_o   <= (bankCnt_q == 2'd2);
              ram0_addr_o <= addrCnt_q;
              ram1_addr_o <= addrCnt_q;
              ram2_addr_o <= addrCnt_q;
              rdCnt_q     <= rdCnt_q + CW'(1);
              if (bankCnt_q == 2'd2) begin
                bankCnt_q <= 2'd0;
                addrCnt_q <= addrCnt_q + RAM_WD'(1);
              end else begin
                bankCnt_q <= bankCnt_q + 2'd1;
              end
            end
          end
          DRAIN: begin
            if (win_valid_o && eol_o) begin
              state_q <= DONE;
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
            end
          end
          DONE: begin
            state_q   <= IDLE;
            rdCnt_q   <= '0;
            bankCnt_q <= '0;
            addrCnt_q <= '0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdData = ram0_rdata_i;
    if (rdBank_q == 2'd1) begin
      rdData = ram1_rdata_i;
    end else if (rdBank_q == 2'd2) begin
      rdData = ram2_rdata_i;
    end
  end

  // The last window has no right neighbour in flight, so it fires on the tap alone.
  assign emit = aValid_q && (pix_valid_o || (winCnt_q == LAST_X));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdValid_q   <= 1'b0;
      rdBank_q    <= '0;
      pix_o       <= '0;
      pix_valid_o <= 1'b0;
      tapA_q      <= '0;
      tapB_q      <= '0;
      aValid_q    <= 1'b0;
      winCnt_q    <= '0;
      win_l_o     <= '0;
      win_c_o     <= '0;
      win_r_o     <= '0;
      win_x_o     <= '0;
      win_valid_o <= 1'b0;
      sol_o       <= 1'b0;
      eol_o       <= 1'b0;
    end else begin
      rdValid_q   <= (ram0_en_o || ram1_en_o || ram2_en_o) && !abortHit;
      rdBank_q    <= ram1_en_o ? 2'd1 : (ram2_en_o ? 2'd2 : 2'd0);
      pix_valid_o <= rdValid_q && !abortHit;
      aValid_q    <= pix_valid_o && !abortHit;
      if (rdValid_q) begin
        pix_o <= rdData;
      end
      if (pix_valid_o) begin
        tapA_q <= pix_o;
        tapB_q <= tapA_q;
      end
      if (abortHit || ((state_q == IDLE) && start_i)) begin
        winCnt_q    <= '0;
        win_valid_o <= 1'b0;
        sol_o       <= 1'b0;
        eol_o       <= 1'b0;
      end else if (emit) begin
        win_l_o     <= (winCnt_q == 10'd0) ? tapA_q : tapB_q;
        win_c_o     <= tapA_q;
        win_r_o     <= (winCnt_q == LAST_X) ? tapA_q : pix_o;
        win_x_o     <= winCnt_q;
        win_valid_o <= 1'b1;
        sol_o       <= (winCnt_q == 10'd0);
        eol_o       <= (winCnt_q == LAST_X);
        winCnt_q    <= winCnt_q + 10'd1;
      end else begin
        win_valid_o <= 1'b0;
        sol_o       <= 1'b0;
        eol_o       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_read_buffer_ctrl.sv
// Bench for read_buffer_ctrl: bank RAM models plus a line-level reference built
// from pixel indices, compared cycle by cycle relative to the start cycle.
module tb_read_buffer_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int L  = 640;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          abort_i;
  logic [DW-1:0] ram0_rdata, ram1_rdata, ram2_rdata;
  logic [AW-1:0] ram0_addr, ram1_addr, ram2_addr;
  logic          ram0_en, ram1_en, ram2_en;
  logic [DW-1:0] pix_o;
  logic          pix_valid_o;
  logic [DW-1:0] win_l_o, win_c_o, win_r_o;
  logic          win_valid_o;
  logic [9:0]    win_x_o;
  logic          sol_o, eol_o, busy_o, done_o;

  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem2 [256];
  logic [DW-1:0] p    [L];

  int checks = 0;
  int errors = 0;

  read_buffer_ctrl #(.DATA_WD(DW), .RAM_WD(AW), .LINE_LEN(L)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .ram0_rdata_i(ram0_rdata), .ram1_rdata_i(ram1_rdata), .ram2_rdata_i(ram2_rdata),
    .ram0_addr_o(ram0_addr), .ram1_addr_o(ram1_addr), .ram2_addr_o(ram2_addr),
    .ram0_en_o(ram0_en), .ram1_en_o(ram1_en), .ram2_en_o(ram2_en),
    .pix_o(pix_o), .pix_valid_o(pix_valid_o),
    .win_l_o(win_l_o), .win_c_o(win_c_o), .win_r_o(win_r_o), .win_valid_o(win_valid_o),
    .win_x_o(win_x_o), .sol_o(sol_o), .eol_o(eol_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous-read bank models: data appears one cycle after the enable.
  initial begin
    ram0_rdata = '0;
    ram1_rdata = '0;
    ram2_rdata = '0;
  end
  always @(posedge clk_i) begin
    if (ram0_en) ram0_rdata <= mem0[ram0_addr];
    if (ram1_en) ram1_rdata <= mem1[ram1_addr];
    if (ram2_en) ram2_rdata <= mem2[ram2_addr];
  end

  task automatic loadLine(input bit ramp);
    for (int i = 0; i < L; i++) begin
      p[i] = ramp ? DW'(i % 256) : DW'($urandom_range(0, 255));
      case (i % 3)
        0:       mem0[i / 3] = p[i];
        1:       mem1[i / 3] = p[i];
        default: mem2[i / 3] = p[i];
      endcase
    end
  endtask

  function automatic logic [74:0] snapOutputs();
    return {ram0_addr, ram1_addr, ram2_addr, ram0_en, ram1_en, ram2_en,
            pix_o, pix_valid_o, win_l_o, win_c_o, win_r_o, win_valid_o,
            win_x_o, sol_o, eol_o, busy_o, done_o};
  endfunction

  // Runs one line from a start in cycle T; cycle c means T+c. A kill (abort or
  // reset) at cycle K leaves everything idle from K+1 onward.
  task automatic runLine(input string name, input int abortAt, input int resetAt,
                         input bit extraStarts, input bit abortWithStart);
    int            killAt;
    int            winCount;
    int            expWinCount;
    int            x;
    bit            alive;
    bit            expPV, expWV;
    logic [2:0]    expEn;
    logic [AW-1:0] expA;
    logic [DW-1:0] eL, eC, eR;
    logic [74:0]   snap;
    killAt   = (abortAt > 0) ? abortAt : ((resetAt > 0) ? resetAt : 1 << 30);
    winCount = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    abort_i = abortWithStart;
    for (int c = 1; c <= L + 12; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      abort_i = 1'b0;
      if (extraStarts && (c == 50 || c == L + 5)) start_i = 1'b1;
      if (c == abortAt) abort_i = 1'b1;
      alive = (c <= killAt);

      expEn = (alive && c <= L) ? (3'b001 << ((c - 1) % 3)) : 3'b000;
      checks++;
      if ({ram2_en, ram1_en, ram0_en} !== expEn) begin
        errors++;
        $display("[TB] FAIL %s enables c=%0d got %b exp %b", name, c, {ram2_en, ram1_en, ram0_en}, expEn);
      end
      if (expEn != 3'b000) begin
        expA = AW'((c - 1) / 3);
        checks++;
        if (ram0_addr !== expA || ram1_addr !== expA || ram2_addr !== expA) begin
          errors++;
          $display("[TB] FAIL %s addr c=%0d got %0d/%0d/%0d exp %0d", name, c, ram0_addr, ram1_addr, ram2_addr, expA);
        end
      end

      expPV = alive && c >= 3 && c <= L + 2;
      checks++;
      if (pix_valid_o !== expPV) begin
        errors++;
        $display("[TB] FAIL %s pix_valid c=%0d got %b exp %b", name, c, pix_valid_o, expPV);
      end
      if (expPV) begin
        checks++;
        if (pix_o !== p[c - 3]) begin
          errors++;
          $display("[TB] FAIL %s pix c=%0d got %0d exp %0d", name, c, pix_o, p[c - 3]);
        end
      end

      expWV = alive && c >= 5 && c <= L + 4;
      if (win_valid_o === 1'b1) winCount++;
      checks++;
      if (win_valid_o !== expWV) begin
        errors++;
        $display("[TB] FAIL %s win_valid c=%0d got %b exp %b", name, c, win_valid_o, expWV);
      end
      if (expWV) begin
        x  = c - 5;
        eL = p[(x == 0) ? 0 : x - 1];
        eC = p[x];
        eR = p[(x == L - 1) ? L - 1 : x + 1];
        checks++;
        if ({win_l_o, win_c_o, win_r_o} !== {eL, eC, eR} || win_x_o !== 10'(x)) begin
          errors++;
          $display("[TB] FAIL %s window c=%0d got x=%0d (%0d,%0d,%0d) exp x=%0d (%0d,%0d,%0d)",
                   name, c, win_x_o, win_l_o, win_c_o, win_r_o, x, eL, eC, eR);
        end
        checks++;
        if ({sol_o, eol_o} !== {(x == 0), (x == L - 1)}) begin
          errors++;
          $display("[TB] FAIL %s sol/eol c=%0d got %b%b exp %b%b", name, c, sol_o, eol_o, (x == 0), (x == L - 1));
        end
      end else begin
        checks++;
        if ({sol_o, eol_o} !== 2'b00) begin
          errors++;
          $display("[TB] FAIL %s sol/eol idle c=%0d got %b%b exp 00", name, c, sol_o, eol_o);
        end
      end

      checks++;
      if (busy_o !== (alive && c <= L + 4)) begin
        errors++;
        $display("[TB] FAIL %s busy c=%0d got %b exp %b", name, c, busy_o, (alive && c <= L + 4));
      end
      checks++;
      if (done_o !== (alive && c == L + 5)) begin
        errors++;
        $display("[TB] FAIL %s done c=%0d got %b exp %b", name, c, done_o, (alive && c == L + 5));
      end

      if (c == resetAt) begin
        rst_ni = 1'b0;
        #1;
        snap = snapOutputs();
        checks++;
        if (snap !== '0) begin
          errors++;
          $display("[TB] FAIL %s async reset outputs got %h exp 0", name, snap);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
      end
    end
    expWinCount = ((killAt < L + 4) ? killAt : L + 4) - 4;
    if (expWinCount < 0) expWinCount = 0;
    checks++;
    if (winCount !== expWinCount) begin
      errors++;
      $display("[TB] FAIL %s window count got %0d exp %0d", name, winCount, expWinCount);
    end
  endtask

  task automatic test_reset();
    logic [74:0] snap;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) @(negedge clk_i);
    snap = snapOutputs();
    checks++;
    if (snap !== '0) begin
      errors++;
      $display("[TB] FAIL reset outputs got %h exp 0", snap);
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_line();
    loadLine(1'b0);
    runLine("line_rand", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_window();
    loadLine(1'b1);
    runLine("window_ramp", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_start_with_abort();
    loadLine(1'b0);
    runLine("start_abort_idle", 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    loadLine(1'b0);
    runLine("abort", 100, 0, 1'b0, 1'b0);
    runLine("after_abort", 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_start();
    loadLine(1'b1);
    runLine("ignore_start", 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midline();
    loadLine(1'b0);
    runLine("reset_mid", 0, 300, 1'b0, 1'b0);
    runLine("after_reset", 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_line();
    test_window();
    test_start_with_abort();
    test_abort();
    test_ignore_start();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_buffer_ctrl.md
READ_BUFFER_CTRL -- requirements
Module: read_buffer_ctrl

Interface
REQ-001 Parameter DATA_WD, default 8, pixel width.
REQ-002 Parameter RAM_WD, default 8, bank address width.
REQ-003 Parameter LINE_LEN, default 640, pixels per line; pixel i is stored in bank i%3 at address i/3.
REQ-004 clk_i  in  1  clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 start_i  in  1  one-cycle request to read one stored line.
REQ-007 abort_i  in  1  cancels a line read in progress.
REQ-008 ram0_rdata_i / ram1_rdata_i / ram2_rdata_i  in  DATA_WD each  bank read data, valid 1 cycle after that bank's enable.
REQ-009 ram0_addr_o / ram1_addr_o / ram2_addr_o  out  RAM_WD each  bank read address, registered.
REQ-010 ram0_en_o / ram1_en_o / ram2_en_o  out  1 each  bank read enable, registered, at most one high per cycle.
REQ-011 pix_o  out  DATA_WD  in-order pixel; pix_valid_o  out  1  qualifier.
REQ-012 win_l_o / win_c_o / win_r_o  out  DATA_WD each  3-tap horizontal window; win_valid_o  out  1  qualifier.
REQ-013 win_x_o  out  10  column of win_c_o; sol_o / eol_o  out  1  window at column 0 / LINE_LEN-1.
REQ-014 busy_o  out  1  line read in progress; done_o  out  1  one-cycle completion pulse.

Function
REQ-015 FSM states IDLE, READ, DRAIN, DONE; all outputs registered.
REQ-016 IDLE: start_i high at cycle T -> READ; first read enable asserted in T+1. start_i ignored in every other state.
REQ-017 READ: one read per cycle, pixel k issued at T+1+k, k=0..LINE_LEN-1; bank = k%3 (rotating 0,1,2), address = k/3, same address driven on all three addr outputs.
REQ-018 Bank counter wraps 2->0 with address increment; last read (k=639) is bank 0, address 213; then -> DRAIN.
REQ-019 Read-data mux uses bank select delayed 1 cycle; pix_o/pix_valid_o for pixel k valid in cycle T+3+k.
REQ-020 Window center x valid in cycle T+5+x; win_l_o=p[x-1], win_c_o=p[x], win_r_o=p[x+1].
REQ-021 Border replication: x=0 -> win_l_o=p[0]; x=LINE_LEN-1 -> win_r_o=p[LINE_LEN-1], produced in flush cycle without new RAM data.
REQ-022 sol_o high only with x=0 window; eol_o high only with x=LINE_LEN-1 window; both qualified by win_valid_o.
REQ-023 DRAIN: enables low; -> DONE the cycle after eol window (T+644 for 640).
REQ-024 DONE: done_o high exactly 1 cycle (T+645), busy_o low; -> IDLE. busy_o high T+1..T+644.
REQ-025 abort_i high in READ/DRAIN: next cycle all enables, pix_valid_o, win_valid_o, busy_o low; no done_o; FSM IDLE; counters cleared. abort_i in IDLE/DONE ignored.
REQ-026 abort_i and start_i same cycle in IDLE: start accepted.
REQ-027 start_i in DONE cycle ignored; new line needs start_i in IDLE.
REQ-028 Address arithmetic in RAM_WD bits; win_x_o counts 0..LINE_LEN-1 without wrap.

Reset
REQ-029 rst_ni low: FSM IDLE; all addresses, enables, pix_o, window taps, win_x_o, valids, sol_o, eol_o, busy_o, done_o = 0; bank and address counters = 0.
REQ-030 Reset mid-line aborts immediately; no done_o after release; first start_i after release reads from pixel 0.

Verification
REQ-031 Banks preloaded p[i]=i%256, start at T -> enables 001,010,100 rotating from T+1, addr 0,0,0,1,...; pix_o=k at T+3+k; done_o only at T+645.
REQ-032 Same line -> window x=0 is (0,0,1) with sol_o; x=5 is (4,5,6); x=639 is (126,127,127) with eol_o; exactly 640 win_valid_o cycles.
REQ-033 Read k=639 -> bank0 enable, address 213; no enable after T+640.
REQ-034 abort_i at T+100 -> all valids/enables/busy_o low from T+101, no done_o; new start -> pixel 0 from address 0.
REQ-035 start_i pulsed at T+50 and in DONE cycle -> ignored; rst_ni low at T+300 -> all outputs 0 asynchronously, no done_o.
